interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4: clk cycles per mtime increment, legal range 1..256.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ext_irq  input  1  external interrupt request, asynchronous to clk.
REQ-005 bus_we  input  1  register write strobe, one write per asserted cycle.
REQ-006 bus_addr  input  3  word index: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 msip, 5-7 unmapped.
REQ-007 bus_wdata  input  32  write data.
REQ-008 bus_rdata  output  32  read data for bus_addr, combinational.
REQ-009 irq_ack  input  1  one-cycle pulse from the exception stage when it takes the interrupt.
REQ-010 interrupt  output  1  request to the exception stage (registered).
REQ-011 irq_code  output  4  cause code of the highest-priority pending source: 11 external, 3 software, 7 timer, 0 none.

Function
REQ-012 ext_irq SHALL pass a 2-flop synchronizer before any use; the synchronized value is sync_ext.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is asserted in the cycle the count equals TICK_DIV-1 (TICK_DIV=1: tick every cycle).
REQ-014 mtime (64-bit) SHALL increment by 1 on tick; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-015 Bus write to mtime_lo/mtime_hi SHALL replace that half and suppress the tick increment in the same cycle (write wins).
REQ-016 mtimecmp (64-bit) and msip (bit 0 only; bits 31:1 read 0) SHALL be written by bus_we at their indices.
REQ-017 mtip SHALL equal (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
REQ-018 Priority SHALL be external > software > timer; irq_code selects the highest set source.
REQ-019 interrupt and irq_code SHALL be registered: asserted the cycle after the source condition becomes true (1-cycle latency), deasserted the cycle after all sources clear.
REQ-020 irq_ack SHALL clear only the external pending flag and only when registered irq_code==11; msip and mtip are cleared solely by software writes.
REQ-021 irq_ack coinciding with a new external rising edge SHALL leave the external pending flag set.
REQ-022 Writes to unmapped indices SHALL be ignored; reads of unmapped indices SHALL return 0.
REQ-023 bus_rdata of mtime SHALL reflect the pre-update value in the cycle of an increment.

Reset
REQ-024 On rst low (immediate, asynchronous): mtime=0, prescaler=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, external pending=0, synchronizer flops=0, interrupt=0, irq_code=0.
REQ-025 Reset asserted mid-count SHALL abandon the count; first tick occurs TICK_DIV cycles after rst deasserts.

Configuration
REQ-026 With INTC_EXT_EDGE_EN defined: external pending is set by a rising edge of sync_ext and held until cleared per REQ-020.
REQ-027 Without INTC_EXT_EDGE_EN: external source is level-sensitive (pending = sync_ext); irq_ack has no effect on it.

Verification
REQ-028 Reset release, TICK_DIV=4, no writes -> mtime_lo reads 5 after 20 cycles, interrupt=0, irq_code=0.
REQ-029 Write mtimecmp_hi=0, mtimecmp_lo=10 -> interrupt=1, irq_code=7 one cycle after mtime reaches 10; write mtimecmp_lo=0xFFFF_FFFF -> interrupt=0 next cycle.
REQ-030 Write mtime_hi=0xFFFF_FFFF, mtime_lo=0xFFFF_FFFF -> next tick reads mtime_hi=0, mtime_lo=0; mtime write coinciding with tick -> written value held.
REQ-031 Edge mode: ext_irq 0->1 held -> interrupt=1, irq_code=11 three cycles later; irq_ack pulse -> cleared, no re-assertion while ext_irq stays 1; level mode -> stays asserted.
REQ-032 msip=1 and timer pending together -> irq_code=3; external edge added -> irq_code=11; ack -> irq_code=3.
REQ-033 rst pulsed low while interrupt=1 -> interrupt=0 and all registers at reset values without a clk edge.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - machine timer, software and external interrupt controller
// INTC_EXT_EDGE_EN: external source latched on rising edge and cleared by irq_ack; otherwise level-sensitive.
module interrupt_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        bus_we,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        irq_ack,
    output logic        interrupt,
    output logic [3:0]  irq_code
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [3:0] CODE_EXT  = 4'd11;
    localparam logic [3:0] CODE_SW   = 4'd3;
    localparam logic [3:0] CODE_TMR  = 4'd7;
    localparam logic [3:0] CODE_NONE = 4'd0;

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_MSIP     = 3'd4;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          interrupt_q, interrupt_d;
    logic [3:0]    irq_code_q, irq_code_d;

    logic tick;
    logic mtip;
    logic sync_ext;
    logic ext_src;

    assign sync_ext = sync2_q;
    assign tick     = (presc_q == PRESC_MAX);
    assign mtip     = (mtime_q >= mtimecmp_q);

`ifdef INTC_EXT_EDGE_EN
    logic sync3_q, sync3_d;
    logic ext_pend_q, ext_pend_d;
    logic ext_rise;
    logic ack_hit;

    // A new edge in the ack cycle must survive the clear, so rise is ORed in last.
    always_comb begin
        sync3_d    = sync_ext;
        ext_rise   = sync_ext & ~sync3_q;
        ack_hit    = irq_ack && (irq_code_q == CODE_EXT);
        ext_pend_d = ext_rise | (ext_pend_q & ~ack_hit);
        ext_src    = ext_pend_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync3_q    <= 1'b0;
            ext_pend_q <= 1'b0;
        end else begin
            sync3_q    <= sync3_d;
            ext_pend_q <= ext_pend_d;
        end
    end
`else
    logic unused_ack;

    always_comb begin
        unused_ack = irq_ack;
        ext_src    = sync_ext;
    end
`endif

    always_comb begin
        sync1_d    = ext_irq;
        sync2_d    = sync1_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        // Bus writes to mtime override the tick increment.
        if (bus_we) begin
            case (bus_addr)
                A_MTIME_LO: mtime_d    = {mtime_q[63:32], bus_wdata};
                A_MTIME_HI: mtime_d    = {bus_wdata, mtime_q[31:0]};
                A_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
                A_CMP_HI:   mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
                A_MSIP:     msip_d     = bus_wdata[0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        interrupt_d = ext_src | msip_q | mtip;
        if (ext_src) begin
            irq_code_d = CODE_EXT;
        end else if (msip_q) begin
            irq_code_d = CODE_SW;
        end else if (mtip) begin
            irq_code_d = CODE_TMR;
        end else begin
            irq_code_d = CODE_NONE;
        end
    end

    always_comb begin
        case (bus_addr)
            A_MTIME_LO: bus_rdata = mtime_q[31:0];
            A_MTIME_HI: bus_rdata = mtime_q[63:32];
            A_CMP_LO:   bus_rdata = mtimecmp_q[31:0];
            A_CMP_HI:   bus_rdata = mtimecmp_q[63:32];
            A_MSIP:     bus_rdata = {31'd0, msip_q};
            default:    bus_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            presc_q     <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= {64{1'b1}};
            msip_q      <= 1'b0;
            interrupt_q <= 1'b0;
            irq_code_q  <= CODE_NONE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            interrupt_q <= interrupt_d;
            irq_code_q  <= irq_code_d;
        end
    end

    assign interrupt = interrupt_q;
    assign irq_code  = irq_code_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - scoreboard bench for interrupt_ctrl (TICK_DIV=4, either external mode)
module tb_interrupt_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ext_irq = 1'b0;
    logic        bus_we = 1'b0;
    logic [2:0]  bus_addr = 3'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        irq_ack = 1'b0;
    logic        interrupt;
    logic [3:0]  irq_code;

`ifdef INTC_EXT_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    interrupt_ctrl #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_irq   (ext_irq),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq_ack   (irq_ack),
        .interrupt (interrupt),
        .irq_code  (irq_code)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    event sample_now;
    bit   stim_done = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq(input logic i, input logic [3:0] c, input string name);
        push(1, {31'd0, i}, {name, "_int"});
        push(2, {28'd0, c}, {name, "_code"});
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        bus_addr = a;
        push(0, exp, name);
        step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        step();
        bus_we    = 1'b0;
    endtask

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk or sample_now);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    0:       act = bus_rdata;
                    1:       act = {31'd0, interrupt};
                    default: act = {28'd0, irq_code};
                endcase
                n_vec++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
            if (stim_done) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk_irq(1'b0, 4'd0, "rst_hold");
        rd(3'd0, 32'd0, "rst_mtime_lo");
        rd(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(3'd4, 32'd0, "rst_msip");
        rst = 1'b1;

        repeat (20) step();
        chk_irq(1'b0, 4'd0, "idle20");
        rd(3'd0, 32'd5, "mtime_after20");

        wr(3'd3, 32'd0);
        wr(3'd2, 32'd10);
        wr(3'd0, 32'd8);
        rd(3'd0, 32'd8, "write_on_tick");
        repeat (6) step();
        chk_irq(1'b0, 4'd0, "tmr_below");
        rd(3'd0, 32'd9, "mtime9");
        chk_irq(1'b0, 4'd0, "tmr_reach");
        rd(3'd0, 32'd10, "mtime10");
        chk_irq(1'b1, 4'd7, "tmr_fire");
        rd(3'd1, 32'd0, "mtime_hi0");
        wr(3'd2, 32'hFFFF_FFFF);
        chk_irq(1'b1, 4'd7, "tmr_cmp_moved");
        rd(3'd2, 32'hFFFF_FFFF, "cmp_lo_rb");
        chk_irq(1'b0, 4'd0, "tmr_clear");
        rd(3'd3, 32'd0, "cmp_hi_rb");

        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFF);
        chk_irq(1'b0, 4'd0, "max_pre");
        rd(3'd0, 32'hFFFF_FFFF, "max_lo");
        chk_irq(1'b1, 4'd7, "max_eq_cmp");
        rd(3'd1, 32'hFFFF_FFFF, "max_hi");
        step();
        rd(3'd0, 32'hFFFF_FFFF, "pre_update_read");
        chk_irq(1'b1, 4'd7, "wrap_lag");
        rd(3'd0, 32'd0, "wrap_lo");
        chk_irq(1'b0, 4'd0, "wrap_clear");
        rd(3'd1, 32'd0, "wrap_hi");

        wr(3'd3, 32'd0);
        wr(3'd2, 32'd0);
        wr(3'd4, 32'hFFFF_FFFF);
        chk_irq(1'b1, 4'd7, "tmr_only");
        rd(3'd4, 32'd1, "msip_rb");
        chk_irq(1'b1, 4'd3, "sw_over_tmr");
        rd(3'd7, 32'd0, "unmapped7");
        wr(3'd5, 32'h1234_5678);
        rd(3'd5, 32'd0, "unmapped5");

        ext_irq = 1'b1;
        step();
        chk_irq(1'b1, 4'd3, "ext_sync1");
        step();
        chk_irq(1'b1, 4'd3, "ext_sync2");
        step();
        chk_irq(1'b1, 4'd11, "ext_fire");
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk_irq(1'b1, EDGE ? 4'd3 : 4'd11, "ext_ack");
        step();
        chk_irq(1'b1, EDGE ? 4'd3 : 4'd11, "ext_held");
        ext_irq = 1'b0;
        rd(3'd4, 32'd1, "msip_sticky");
        step();
        ext_irq = 1'b1;
        step();
        step();
        ext_irq = 1'b0;
        step();
        chk_irq(1'b1, 4'd11, "edge2_fire");
        step();
        chk_irq(1'b1, 4'd11, "edge2_hold");
        ext_irq = 1'b1;
        step();
        chk_irq(1'b1, EDGE ? 4'd11 : 4'd3, "edge2_low1");
        step();
        chk_irq(1'b1, EDGE ? 4'd11 : 4'd3, "edge2_low2");
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk_irq(1'b1, 4'd11, "ack_with_edge");
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk_irq(1'b1, EDGE ? 4'd3 : 4'd11, "ack_after_edge");

        step();
        push(1, 32'd1, "pre_arst_int");
        push(2, EDGE ? 32'd3 : 32'd11, "pre_arst_code");
        ->sample_now;
        #1;
        rst      = 1'b0;
        ext_irq  = 1'b0;
        bus_addr = 3'd0;
        #1;
        if (interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL arst_direct_int: got %0b expected 0", interrupt);
        end
        if (irq_code !== 4'd0) begin
            n_err++;
            $display("FAIL arst_direct_code: got %0d expected 0", irq_code);
        end
        if (bus_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL arst_direct_mtime: got 0x%08h expected 0x00000000", bus_rdata);
        end
        chk_irq(1'b0, 4'd0, "arst");
        push(0, 32'd0, "arst_mtime_lo");
        ->sample_now;
        #1;
        bus_addr = 3'd2;
        #1;
        push(0, 32'hFFFF_FFFF, "arst_cmp_lo");
        ->sample_now;
        #1;
        bus_addr = 3'd3;
        #1;
        push(0, 32'hFFFF_FFFF, "arst_cmp_hi");
        ->sample_now;
        #1;
        bus_addr = 3'd4;
        #1;
        push(0, 32'd0, "arst_msip");
        ->sample_now;
        #1;
        step();
        rst = 1'b1;
        repeat (3) step();
        rd(3'd0, 32'd0, "first_tick_pre");
        chk_irq(1'b0, 4'd0, "post_rst");
        rd(3'd0, 32'd1, "first_tick");

        step();
        step();
        stim_done = 1'b1;
        ->sample_now;
    end

endmodule
